shift_seq: RTL

SHIFT_SEQ -- requirements
Module: shift_seq

---
 rtl/shift_seq.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/shift_seq.sv
// Framed MSB-first serial shifter: transmits a word on sout while capturing sin.
// Optional even parity bit after each frame when SHIFT_SEQ_PARITY_EN is defined.
module shift_seq #(
   parameter int N   = 8,
   parameter int GAP = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic         sin,
   output logic         sout,
   output logic         frame,
   output logic         rx_valid,
   output logic [N-1:0] rx_data
);

   localparam int CW = $clog2(N + 1);
   localparam int GW = 4;
   localparam logic [CW-1:0] CLAST = CW'(N - 1);
   localparam logic [GW-1:0] GLAST = GW'((GAP > 0) ? GAP - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
`ifdef SHIFT_SEQ_PARITY_EN
      ,
      S_PAR   = 2'd3
`endif
   } state_t;

   localparam state_t POST_ST = (GAP > 0) ? S_GAP : S_IDLE;

   state_t        st;
   state_t        nxt;
   logic [N-1:0]  q;
   logic [CW-1:0] cnt;
   logic [GW-1:0] gcnt;
   logic          accept;
   logic          last;

`ifdef SHIFT_SEQ_PARITY_EN
   logic          par;
`endif

   assign accept = in_valid & in_ready;
   assign last   = (cnt == CLAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st <= S_IDLE;
      end else begin
         st <= nxt;
      end
   end

   always_comb begin
      nxt = st;
      unique case (st)
         S_IDLE: begin
            if (accept) nxt = S_SHIFT;
         end
         S_SHIFT: begin
`ifdef SHIFT_SEQ_PARITY_EN
            if (last) nxt = S_PAR;
`else
            if (last) nxt = POST_ST;
`endif
         end
`ifdef SHIFT_SEQ_PARITY_EN
         S_PAR: begin
            nxt = POST_ST;
         end
`endif
         S_GAP: begin
            if (gcnt == GLAST) nxt = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
   end

   // in_ready is gated by reset so it stays low while reset is held
   always_comb begin
      in_ready = 1'b0;
      frame    = 1'b0;
      sout     = 1'b0;
      unique case (st)
         S_IDLE: begin
            in_ready = reset;
         end
         S_SHIFT: begin
            frame = 1'b1;
            sout  = q[N-1];
         end
`ifdef SHIFT_SEQ_PARITY_EN
         S_PAR: begin
            frame = 1'b1;
            sout  = par;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q        <= '0;
         cnt      <= '0;
         gcnt     <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         unique case (st)
            S_IDLE: begin
               if (accept) begin
                  q   <= in_data;
                  cnt <= '0;
               end
            end
            S_SHIFT: begin
               q   <= {q[N-2:0], sin};
               cnt <= cnt + 1'b1;
               if (last) begin
                  rx_data  <= {q[N-2:0], sin};
                  rx_valid <= 1'b1;
                  gcnt     <= '0;
               end
            end
            S_GAP: begin
               gcnt <= gcnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef SHIFT_SEQ_PARITY_EN
   // tx bits are shifted out of q, so parity is latched at accept
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         par <= 1'b0;
      end else if (accept) begin
         par <= ^in_data;
      end
   end
`endif

endmodule
